dmem_mmio: RTL and testbench



---
 rtl/dmem_mmio.sv | 147 ++++++++++++++
 tb/tb_dmem_mmio.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_mmio
//  Purpose  : Data-side memory responder for the pipelined ARM core.
//             Word-addressed RAM plus a 256-byte register page holding a
//             free-running cycle counter, a scratch register and a byte
//             output FIFO drained by an external valid/ready consumer.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_mmio #(
    parameter int          MEM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam int              c_IDX_W     = $clog2(MEM_WORDS);
    localparam int              c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [3:0]      c_DEPTH     = 4'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    localparam logic [7:0] c_OFF_CYCLE   = 8'h00;
    localparam logic [7:0] c_OFF_OUT     = 8'h04;
    localparam logic [7:0] c_OFF_STATUS  = 8'h08;
    localparam logic [7:0] c_OFF_SCRATCH = 8'h0C;

    // Storage
    logic [31:0]        r_mem [MEM_WORDS];
    logic [7:0]         r_buf [FIFO_DEPTH];

    // Register page state
    logic [31:0]        r_cycle;
    logic [31:0]        r_scratch;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [3:0]         r_count;
    logic               r_overflow;

    // Decode and FIFO handshake
    logic               w_isMmio;
    logic [7:0]         w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_pushReq;
    logic               w_pushOk;
    logic               w_statusWr;
    logic               w_scratchWr;
    logic               w_ramWr;

    assign w_isMmio    = (a[31:8] == MMIO_BASE[31:8]);
    assign w_off       = a[7:0];
    assign w_idx       = a[c_IDX_W+1:2];

    assign w_empty     = (r_count == 4'd0);
    assign w_full      = (r_count == c_DEPTH);
    // out_valid is purely registered state, so out_ready never reaches it.
    assign w_pop       = !w_empty && out_ready;
    assign w_pushReq   = we && w_isMmio && (w_off == c_OFF_OUT);
    // A full FIFO still accepts when the head is leaving in the same cycle.
    assign w_pushOk    = w_pushReq && (!w_full || w_pop);
    assign w_statusWr  = we && w_isMmio && (w_off == c_OFF_STATUS);
    assign w_scratchWr = we && w_isMmio && (w_off == c_OFF_SCRATCH);
    assign w_ramWr     = we && !w_isMmio;

    assign out_valid   = !w_empty;
    assign out_data    = r_buf[r_rdPtr];

    // Combinational read mux: register page or RAM word
    always_comb begin
        rd = 32'h0;
        if (w_isMmio) begin
            case (w_off)
                c_OFF_CYCLE:   rd = r_cycle;
                c_OFF_STATUS:  rd = {24'h0, r_count, 1'b0, r_overflow, w_full, w_empty};
                c_OFF_SCRATCH: rd = r_scratch;
                default:       rd = 32'h0;
            endcase
        end else begin
            rd = r_mem[w_idx];
        end
    end

    // RAM write port; contents survive reset but a write during reset is dropped
    always_ff @(posedge clk) begin
        if (w_ramWr && !reset) begin
            r_mem[w_idx] <= wd;
        end
    end

    // FIFO byte storage; not cleared, only the pointers and count are
    always_ff @(posedge clk) begin
        if (w_pushOk && !reset) begin
            r_buf[r_wrPtr] <= wd[7:0];
        end
    end

    // Counter, scratch, FIFO bookkeeping and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle    <= 32'h0;
            r_scratch  <= 32'h0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;

            if (w_scratchWr) begin
                r_scratch <= wd;
            end

            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end

            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase

            // Set and clear are different offsets, so they never collide.
            if (w_pushReq && !w_pushOk) begin
                r_overflow <= 1'b1;
            end else if (w_statusWr && wd[2]) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_mmio
//  Purpose  : Self-checking bench for dmem_mmio: directed scenarios plus a
//             randomized run against a queue/array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_mmio;

    localparam int          c_WORDS = 64;
    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_CYC   = 32'hFFFF_FF00;
    localparam logic [31:0] c_OUT   = 32'hFFFF_FF04;
    localparam logic [31:0] c_STAT  = 32'hFFFF_FF08;
    localparam logic [31:0] c_SCR   = 32'hFFFF_FF0C;
    localparam logic [31:0] c_HOLE  = 32'hFFFF_FF10;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    dmem_mmio #(
        .MEM_WORDS (c_WORDS),
        .FIFO_DEPTH(c_DEPTH),
        .MMIO_BASE (c_CYC)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .wd       (wd),
        .we       (we),
        .rd       (rd),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mMem [c_WORDS];
    logic [31:0] mCycle;
    logic [31:0] mScratch;
    logic        mOvf;
    logic [7:0]  mq [$];

    int nRun  = 0;
    int nFail = 0;

    // Observed / expected values of the most recent cycle
    logic [31:0] obsRd;
    logic        obsValid;
    logic [7:0]  obsData;
    logic [31:0] expRd;
    logic        expValid;
    logic [7:0]  expData;

    function automatic logic [31:0] mdlRead(input logic [31:0] addr);
        int cnt;
        cnt = mq.size();
        if (addr[31:8] == c_CYC[31:8]) begin
            case (addr[7:0])
                8'h00:   return mCycle;
                8'h08:   return {24'h0, 4'(cnt), 1'b0, mOvf, (cnt == c_DEPTH), (cnt == 0)};
                8'h0C:   return mScratch;
                default: return 32'h0;
            endcase
        end
        return mMem[(addr >> 2) % c_WORDS];
    endfunction

    task automatic mdlEdge(input logic [31:0] addr, input logic [31:0] data,
                           input logic wen, input logic rdy, input logic rst);
        logic isM;
        logic popped;
        logic wasFull;
        if (rst) begin
            mCycle   = 32'h0;
            mScratch = 32'h0;
            mOvf     = 1'b0;
            mq.delete();
            return;
        end
        mCycle  = mCycle + 32'd1;
        isM     = (addr[31:8] == c_CYC[31:8]);
        popped  = (mq.size() > 0) && rdy;
        wasFull = (mq.size() == c_DEPTH);
        if (popped) void'(mq.pop_front());
        if (wen && isM && addr[7:0] == 8'h04) begin
            if (!wasFull || popped) mq.push_back(data[7:0]);
            else mOvf = 1'b1;
        end
        if (wen && isM && addr[7:0] == 8'h08 && data[2]) mOvf = 1'b0;
        if (wen && isM && addr[7:0] == 8'h0C) mScratch = data;
        if (wen && !isM) mMem[(addr >> 2) % c_WORDS] = data;
    endtask

    // One bus cycle: drive, sample mid-cycle, then advance DUT and model together
    task automatic tick(input logic [31:0] addr, input logic [31:0] data,
                        input logic wen, input logic rdy, input logic rst);
        @(negedge clk);
        a = addr; wd = data; we = wen; out_ready = rdy; reset = rst;
        #1;
        obsRd    = rd;
        obsValid = out_valid;
        obsData  = out_data;
        expRd    = mdlRead(addr);
        expValid = (mq.size() != 0);
        expData  = expValid ? mq[0] : 8'h00;
        @(posedge clk);
        mdlEdge(addr, data, wen, rdy, rst);
    endtask

    task automatic test_reset();
        tick(c_CYC, 0, 1'b0, 1'b0, 1'b1);
        tick(c_CYC, 0, 1'b0, 1'b0, 1'b1);
        tick(c_CYC, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h0) begin nFail++; $display("FAIL reset_cycle got %h exp %h", obsRd, 32'h0); end
        tick(c_STAT, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h1) begin nFail++; $display("FAIL reset_status got %h exp %h", obsRd, 32'h1); end
        nRun++;
        if (obsValid !== 1'b0) begin nFail++; $display("FAIL reset_valid got %b exp 0", obsValid); end
        tick(c_SCR, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h0) begin nFail++; $display("FAIL reset_scratch got %h exp %h", obsRd, 32'h0); end
    endtask

    task automatic test_ram();
        for (int i = 0; i < c_WORDS; i++) tick(32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0);
        tick(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        tick(32'h10, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL ram_rd got %h exp %h", obsRd, 32'hDEAD_BEEF); end
        tick(32'h110, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL ram_alias got %h exp %h", obsRd, 32'hDEAD_BEEF); end
        tick(32'h14, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== expRd) begin nFail++; $display("FAIL ram_neighbour got %h exp %h", obsRd, expRd); end
        tick(32'h13, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL ram_lowbits got %h exp %h", obsRd, 32'hDEAD_BEEF); end
    endtask

    task automatic test_cycle();
        logic [31:0] v [3];
        for (int i = 0; i < 3; i++) begin
            tick(c_CYC, 0, 1'b0, 1'b0, 1'b0);
            v[i] = obsRd;
            if (i == 0) begin
                nRun++;
                if (obsRd !== expRd) begin nFail++; $display("FAIL cycle_abs got %h exp %h", obsRd, expRd); end
            end
        end
        nRun++;
        if (v[1] !== v[0] + 32'd1) begin nFail++; $display("FAIL cycle_inc1 got %h exp %h", v[1], v[0] + 32'd1); end
        nRun++;
        if (v[2] !== v[1] + 32'd1) begin nFail++; $display("FAIL cycle_inc2 got %h exp %h", v[2], v[1] + 32'd1); end
        tick(c_CYC, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        tick(c_CYC, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h0) begin nFail++; $display("FAIL cycle_reset got %h exp %h", obsRd, 32'h0); end
    endtask

    task automatic test_fifo();
        for (int i = 0; i < 4; i++) tick(c_OUT, 32'h41 + 32'(i), 1'b1, 1'b0, 1'b0);
        tick(c_STAT, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h42) begin nFail++; $display("FAIL fifo_full_status got %h exp %h", obsRd, 32'h42); end
        tick(c_OUT, 32'h45, 1'b1, 1'b0, 1'b0);
        tick(c_STAT, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h46) begin nFail++; $display("FAIL fifo_ovf_status got %h exp %h", obsRd, 32'h46); end
        for (int i = 0; i < 4; i++) begin
            tick(c_STAT, 0, 1'b0, 1'b1, 1'b0);
            nRun++;
            if (obsValid !== 1'b1 || obsData !== 8'h41 + 8'(i)) begin
                nFail++; $display("FAIL fifo_drain%0d got v=%b d=%h exp v=1 d=%h", i, obsValid, obsData, 8'h41 + 8'(i));
            end
        end
        tick(c_STAT, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsValid !== 1'b0) begin nFail++; $display("FAIL fifo_empty_valid got %b exp 0", obsValid); end
        nRun++;
        if (obsRd !== 32'h05) begin nFail++; $display("FAIL fifo_empty_status got %h exp %h", obsRd, 32'h05); end
        tick(c_OUT, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h0) begin nFail++; $display("FAIL out_read got %h exp %h", obsRd, 32'h0); end
    endtask

    task automatic test_status_scratch();
        tick(c_STAT, 32'h4, 1'b1, 1'b0, 1'b0);
        tick(c_STAT, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h01) begin nFail++; $display("FAIL ovf_clear got %h exp %h", obsRd, 32'h01); end
        tick(c_SCR, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        tick(c_SCR, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h1234_5678) begin nFail++; $display("FAIL scratch_rw got %h exp %h", obsRd, 32'h1234_5678); end
        tick(c_CYC, 32'hAAAA_5555, 1'b1, 1'b0, 1'b0);
        tick(c_CYC, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== expRd) begin nFail++; $display("FAIL cycle_ro got %h exp %h", obsRd, expRd); end
        tick(c_HOLE, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        tick(c_HOLE, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h0) begin nFail++; $display("FAIL hole_read got %h exp %h", obsRd, 32'h0); end
        tick(c_SCR, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h1234_5678) begin nFail++; $display("FAIL scratch_keep got %h exp %h", obsRd, 32'h1234_5678); end
        tick(c_SCR, 0, 1'b0, 1'b0, 1'b1);
        tick(c_SCR, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h0) begin nFail++; $display("FAIL scratch_reset got %h exp %h", obsRd, 32'h0); end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) tick(c_OUT, 32'h11 + 32'(i), 1'b1, 1'b0, 1'b0);
        tick(c_OUT, 32'h55, 1'b1, 1'b1, 1'b0);
        nRun++;
        if (obsData !== 8'h11) begin nFail++; $display("FAIL simul_head got %h exp %h", obsData, 8'h11); end
        tick(c_STAT, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h42) begin nFail++; $display("FAIL simul_status got %h exp %h", obsRd, 32'h42); end
        for (int i = 0; i < 4; i++) begin
            tick(c_STAT, 0, 1'b0, 1'b1, 1'b0);
            nRun++;
            if (obsValid !== 1'b1 || obsData !== ((i == 3) ? 8'h55 : 8'h12 + 8'(i))) begin
                nFail++; $display("FAIL simul_drain%0d got v=%b d=%h", i, obsValid, obsData);
            end
        end
        tick(c_STAT, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsRd !== 32'h01) begin nFail++; $display("FAIL simul_final got %h exp %h", obsRd, 32'h01); end
    endtask

    task automatic test_reset_push();
        for (int i = 0; i < 5; i++) tick(c_OUT, 32'h61 + 32'(i), 1'b1, 1'b0, 1'b0);
        tick(c_OUT, 32'h66, 1'b1, 1'b0, 1'b1);
        tick(c_STAT, 0, 1'b0, 1'b0, 1'b0);
        nRun++;
        if (obsValid !== 1'b0) begin nFail++; $display("FAIL rstpush_valid got %b exp 0", obsValid); end
        nRun++;
        if (obsRd !== 32'h01) begin nFail++; $display("FAIL rstpush_status got %h exp %h", obsRd, 32'h01); end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic        wen;
        logic        rst;
        logic [7:0]  offs [6];
        offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08;
        offs[3] = 8'h0C; offs[4] = 8'h10; offs[5] = 8'h04;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                addr = $urandom & 32'h0000_03FF;
            end else begin
                addr = {c_CYC[31:8], ($urandom_range(0, 7) == 0) ? 8'($urandom) : offs[$urandom_range(0, 5)]};
            end
            rst = ($urandom_range(0, 99) == 0);
            wen = rst ? 1'b0 : 1'($urandom_range(0, 1));
            tick(addr, $urandom, wen, 1'($urandom_range(0, 2) == 0), rst);
            nRun++;
            if (obsRd !== expRd) begin nFail++; $display("FAIL rand_rd @%0d a=%h got %h exp %h", n, addr, obsRd, expRd); end
            nRun++;
            if (obsValid !== expValid) begin nFail++; $display("FAIL rand_valid @%0d got %b exp %b", n, obsValid, expValid); end
            if (expValid) begin
                nRun++;
                if (obsData !== expData) begin nFail++; $display("FAIL rand_data @%0d got %h exp %h", n, obsData, expData); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; a = 32'h0; wd = 32'h0; we = 1'b0; out_ready = 1'b0;
        test_reset();
        test_ram();
        test_cycle();
        test_fifo();
        test_status_scratch();
        test_full_simul();
        test_reset_push();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
`default_nettype wire
